// File: rtl/prefetch_pkg.sv
// Shared types for the instruction prefetcher: fetch FSM states, queue entry layout
// and the default widths that the entry layout is built from.
package prefetch_pkg;

  localparam int PF_ADDR_BITS   = 6;
  localparam int PF_INSTR_BITS  = 32;
  localparam int PF_QUEUE_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PF_ADDR_BITS-1:0]  pc;
    logic [PF_INSTR_BITS-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush; a push and pop
// in the same cycle are legal even when full, leaving the count unchanged.
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int DEPTH = PF_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  fetch_entry_t             i_entry,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_COUNT = DEPTH[PW:0];
  localparam logic [PW:0]   COUNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE    = 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_full    = (r_count == FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_do_push && !w_do_pop)      r_count <= r_count + COUNT_ONE;
      else if (w_do_pop && !w_do_push) r_count <= r_count - COUNT_ONE;
    end
  end

  // NOTE: entry storage is deliberately not reset; the count marks which slots are
  // live and the top gates the head outputs while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_prefetcher.sv
// Per-core program memory read initiator: walks a fetch PC one request at a time
// and buffers returned instructions with their PC for the decoder.
module instruction_prefetcher
  import prefetch_pkg::*;
#(
  // Entry layout comes from prefetch_pkg, so these must match its widths.
  parameter int PROGRAM_ADDR_BITS = PF_ADDR_BITS,
  parameter int INSTR_BITS        = PF_INSTR_BITS,
  parameter int QUEUE_DEPTH       = PF_QUEUE_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         redirect_valid,
  input  logic [PROGRAM_ADDR_BITS-1:0] redirect_pc,
  output logic                         instr_valid,
  output logic [INSTR_BITS-1:0]        instr_data,
  output logic [PROGRAM_ADDR_BITS-1:0] instr_pc,
  input  logic                         instr_ready,
  output logic                         mem_read_valid,
  output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
  input  logic                         mem_read_ready,
  input  logic [INSTR_BITS-1:0]        mem_read_data
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0]                DEPTH_COUNT = QUEUE_DEPTH[CW-1:0];
  localparam logic [PROGRAM_ADDR_BITS-1:0] PC_STEP     = 1;

  fetch_state_e                 r_state;
  logic [PROGRAM_ADDR_BITS-1:0] r_fetch_pc;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_empty;
  logic                         w_slot_free;
  logic [CW-1:0]                w_count;
  fetch_entry_t                 w_push_entry;
  fetch_entry_t                 w_head;

  // Only a response seen while in REQ is genuine; ready in DRAIN/IDLE is stale.
  assign w_push       = (r_state == REQ) && mem_read_ready && !redirect_valid;
  assign w_pop        = instr_valid && instr_ready;
  assign w_slot_free  = (w_count < DEPTH_COUNT);
  assign w_push_entry = '{pc: r_fetch_pc, instr: mem_read_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_state    <= (r_state == REQ) ? DRAIN : IDLE;
    end else begin
      case (r_state)
        IDLE:    if (enable && w_slot_free) r_state <= REQ;
        REQ: begin
          if (mem_read_ready) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
            r_state    <= DRAIN;
          end
        end
        DRAIN:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  prefetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign instr_valid      = !w_empty;
  assign instr_data       = w_empty ? '0 : w_head.instr;
  assign instr_pc         = w_empty ? '0 : w_head.pc;
  assign mem_read_valid   = (r_state == REQ);
  assign mem_read_address = r_fetch_pc;

endmodule

// File: tb/tb_instruction_prefetcher.sv
// Bench for instruction_prefetcher: a one-cycle-late program memory responder plus a
// sequential-PC stream model that every instruction handed to the decoder must match.
module tb_instruction_prefetcher;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready = 1'b0;
  logic [DW-1:0] mem_read_data  = '0;

  instruction_prefetcher dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_data       (instr_data),
    .instr_pc         (instr_pc),
    .instr_ready      (instr_ready),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  // Program memory: ready and data are registered from the previous cycle's request.
  // stretch_ready keeps ready high one extra cycle after valid drops.
  logic [DW-1:0] mem [64];
  logic          stretch_ready = 1'b0;
  logic          prev_valid    = 1'b0;

  always @(posedge clk) begin
    mem_read_ready <= mem_read_valid || (stretch_ready && prev_valid);
    prev_valid     <= mem_read_valid;
    mem_read_data  <= mem[mem_read_address];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stream model: the decoder must see consecutive PCs starting at the last
  // redirect (or 0 after reset), each carrying mem[pc].
  logic [AW-1:0] exp_pc       = '0;
  int            pops         = 0;
  int            cyc          = 0;
  int            last_req_cyc = -1;
  int            req_rises    = 0;
  int            valid_cycles = 0;
  logic [AW-1:0] last_req_addr = '0;
  logic          prev_hold    = 1'b0;
  logic [AW-1:0] prev_pc      = '0;
  logic          prev_mrv     = 1'b0;
  logic [AW-1:0] pop_log [$];

  // Called just after a falling edge with inputs set for the coming rising edge.
  task automatic tick();
    if (reset) begin
      exp_pc       = '0;
      prev_hold    = 1'b0;
      last_req_cyc = -1;
      prev_mrv     = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", instr_valid, 1'b1);
        check("hold_pc", instr_pc, prev_pc);
      end
      if (instr_valid && instr_ready) begin
        check("pop_pc", instr_pc, exp_pc);
        check("pop_data", instr_data, mem[exp_pc]);
        pop_log.push_back(instr_pc);
        exp_pc++;
        pops++;
      end
      if (mem_read_valid && !prev_mrv) begin
        if (last_req_cyc >= 0) check("req_gap_ge3", (cyc - last_req_cyc) >= 3, 1'b1);
        last_req_cyc  = cyc;
        req_rises++;
        last_req_addr = mem_read_address;
      end
      prev_hold = instr_valid && !instr_ready && !redirect_valid;
      prev_pc   = instr_pc;
      prev_mrv  = mem_read_valid;
      if (redirect_valid) exp_pc = redirect_pc;
    end
    if (instr_valid) valid_cycles++;
    cyc++;
    @(negedge clk);
  endtask

  int p0;
  int r0;
  int n0;

  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = 32'hA0A0_0000 | i;

    @(negedge clk);
    tick();
    tick();
    check("rst_mem_valid", mem_read_valid, 1'b0);
    check("rst_mem_addr", mem_read_address, '0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr_pc", instr_pc, '0);
    check("rst_instr_data", instr_data, '0);

    // 1: straight-line fetch of pc 0..3, each head visible for one cycle.
    reset        = 1'b0;
    enable       = 1'b1;
    instr_ready  = 1'b1;
    valid_cycles = 0;
    for (int i = 0; i < 80 && pops < 4; i++) tick();
    check("t1_pops", pops, 4);
    check("t1_valid_width", valid_cycles, 4);
    check("t1_pc_order", {pop_log[0], pop_log[1], pop_log[2], pop_log[3]}, {6'd0, 6'd1, 6'd2, 6'd3});

    // 2: stalled decoder -> exactly two fetches, then resume at pc 2.
    enable = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = '0;
    tick();
    redirect_valid = 1'b0;
    enable         = 1'b1;
    instr_ready    = 1'b0;
    r0             = req_rises;
    for (int i = 0; i < 40; i++) tick();
    check("t2_fetched", req_rises - r0, 2);
    check("t2_req_idle", mem_read_valid, 1'b0);
    check("t2_head_valid", instr_valid, 1'b1);
    check("t2_head_pc", instr_pc, 6'd0);
    instr_ready = 1'b1;
    r0          = req_rises;
    for (int i = 0; i < 20 && req_rises == r0; i++) tick();
    check("t2_resumed", req_rises > r0, 1'b1);
    check("t2_resume_addr", last_req_addr, 6'd2);

    // 3: redirect to 5 in the cycle the response arrives.
    for (int i = 0; i < 20 && !(mem_read_valid && mem_read_ready); i++) tick();
    check("t3_found_resp", mem_read_valid && mem_read_ready, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 6'd5;
    tick();
    redirect_valid = 1'b0;
    check("t3_flushed_c1", instr_valid, 1'b0);
    tick();
    check("t3_flushed_c2", instr_valid, 1'b0);
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    check("t3_next_pc", instr_pc, 6'd5);

    // 4: PC wrap 62 -> 63 -> 0.
    redirect_valid = 1'b1;
    redirect_pc    = 6'd62;
    tick();
    redirect_valid = 1'b0;
    n0 = pop_log.size();
    for (int i = 0; i < 60 && pop_log.size() < n0 + 3; i++) tick();
    check("t4_count", pop_log.size() >= n0 + 3, 1'b1);
    if (pop_log.size() >= n0 + 3) begin
      check("t4_pc62", pop_log[n0], 6'd62);
      check("t4_pc63", pop_log[n0+1], 6'd63);
      check("t4_wrap0", pop_log[n0+2], 6'd0);
    end

    // 5: stale ready held through DRAIN must not duplicate an entry.
    stretch_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 60 && pops < p0 + 4; i++) tick();
    check("t5_pops", pops - p0, 4);
    stretch_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // 6: reset during an open request.
    for (int i = 0; i < 20 && !mem_read_valid; i++) tick();
    check("t6_in_req", mem_read_valid, 1'b1);
    reset = 1'b1;
    tick();
    check("t6_mem_valid", mem_read_valid, 1'b0);
    check("t6_instr_valid", instr_valid, 1'b0);
    check("t6_addr", mem_read_address, 6'd0);
    check("t6_instr_pc", instr_pc, 6'd0);
    reset = 1'b0;

    // Random traffic: stalls, enable gaps, redirects and occasional resets.
    p0 = pops;
    for (int i = 0; i < 2000; i++) begin
      enable         = ($urandom_range(0, 9) != 0);
      instr_ready    = $urandom_range(0, 1);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = AW'($urandom);
      reset          = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    check("rand_progress", (pops - p0) > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
